cart_mem_arb: RTL and testbench
===============================

Name: cart_mem_arb

Overview:
- Shares one external word-wide memory (SDRAM/BRAM controller port) between the board's cartridge read bus and a ROM loader write port.
- Detects cartridge read cycles from cart_cs/cart_oe/cart_address, issues memory reads and holds the returned word on cart_data for the board.
- Serves loader writes in gaps between cart reads.
- Includes a one-word read cache and a response watchdog.

Parameters:
- ADDR_W, 21, word address width (matches cart_address).
- DATA_W, 16, data word width.
- TIMEOUT, 63, max MCLK cycles to wait for mem_rvalid before aborting a read.

Ports:
- MCLK  in  1  system clock.
- SRES  in  1  asynchronous active-low reset.
- cart_address  in  ADDR_W  board cart word address.
- cart_cs  in  1  board chip select, active high.
- cart_oe  in  1  board output enable, active high.
- cart_data  out  DATA_W  read word returned to board.
- cart_valid  out  1  cart_data holds the word for the current cart_address.
- ld_req  in  1  loader write request, level, held until ld_ack.
- ld_addr  in  ADDR_W  loader word address.
- ld_data  in  DATA_W  loader write data.
- ld_ack  out  1  one-cycle pulse: loader write accepted by memory.
- mem_req  out  1  memory command valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  write data.
- mem_ready  in  1  memory accepts command when mem_req & mem_ready.
- mem_rdata  in  DATA_W  read data.
- mem_rvalid  in  1  one-cycle read data strobe.
- timeout_err  out  1  sticky: a read timed out; cleared only by reset.

Behaviour:
- Reset (SRES low, asynchronous) forces the following; all outputs are registered.
  - State IDLE.
  - cart_data = all ones (16'hFFFF).
  - cart_valid = 0, ld_ack = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, timeout_err = 0.
  - Cache tag invalid, watchdog counter = 0.
- sel = cart_cs & cart_oe. A cart access is pending when sel = 1 and (cache invalid or cart_address != cache tag).
- Cache hit (sel = 1, tag valid, address equal): cart_valid = 1 on the next cycle, no memory command issued.
- cart_valid drops to 0 the cycle after sel falls or cart_address changes to a non-hit value. cart_data keeps its last value.
- States:
  - IDLE:
    - Cart access pending -> RD_CMD; latch cart_address into the tag register, tag marked invalid.
    - Else ld_req -> WR_CMD; latch ld_addr/ld_data.
    - Cart has strict priority when both are pending in the same cycle.
  - RD_CMD: mem_req = 1, mem_we = 0, mem_addr = latched address. On mem_ready -> RD_WAIT, mem_req = 0 next cycle, counter cleared.
  - RD_WAIT:
    - On mem_rvalid: cart_data <= mem_rdata, tag valid; -> IDLE. cart_valid = 1 next cycle if sel is still set and the address still matches.
    - Counter increments each cycle. On reaching TIMEOUT with no rvalid: cart_data <= all ones, tag stays invalid, timeout_err = 1, -> IDLE.
    - A late rvalid arriving in IDLE is ignored.
  - WR_CMD:
    - mem_req = 1, mem_we = 1, mem_addr/mem_wdata = latched values.
    - On mem_ready: ld_ack pulses 1 cycle, -> IDLE.
    - If ld_addr equals the valid cache tag, the tag is invalidated (coherency).
- A write in WR_CMD is never preempted. A cart access arriving meanwhile waits, with worst-case latency one write plus one read.
- Address change during RD_CMD/RD_WAIT: the outstanding read completes and fills the cache for the old address. The new address is then pending from IDLE. Stale data is never flagged valid.
- Read latency from sel rising (miss) to cart_valid: 1 (IDLE) + 1 (RD_CMD, if mem_ready) + memory latency + 1 cycle.
- After IDLE, ld_ack is never asserted twice for one ld_req assertion: the loader must drop ld_req for at least 1 cycle or present the next word. ld_req held high after ld_ack is treated as a new request.
- Counter width is clog2(TIMEOUT+1). TIMEOUT is counted in cycles after command acceptance.

Test Plan:
- Reset mid-read:
  - Assert sel with addr 0x00100, mem_ready = 1, and drop SRES while in RD_WAIT.
  - Expect cart_data = 0xFFFF, cart_valid = 0, mem_req = 0 immediately. No activity after release until sel is re-evaluated.
- Miss then hit:
  - Addr 0x00200, memory returns 0xA55A 3 cycles after accept -> cart_valid = 1 with cart_data = 0xA55A.
  - Deassert sel, reassert at the same address -> cart_valid in 1 cycle, zero new mem_req.
- Simultaneous requests:
  - ld_req (addr 0x00010, data 0x1234) and a cart miss (addr 0x00020) in the same cycle.
  - Expect a read command to 0x00020 first. The write follows, with ld_ack pulsing once.
- Write invalidates cache:
  - Cache holds tag 0x00300 with data 0x1111. Loader writes 0x2222 to 0x00300.
  - The next cart read of 0x00300 issues a memory read and returns 0x2222.
- Timeout:
  - Read 0x00400, memory never asserts rvalid.
  - After TIMEOUT = 63 cycles: cart_data = 0xFFFF, timeout_err = 1, state IDLE. A later rvalid is ignored.
- Backpressure: mem_ready held 0 for 10 cycles during RD_CMD -> mem_req and mem_addr stay stable, and the watchdog does not count.

Source files
------------

// File: rtl/cart_mem_arb.sv
// rtl/cart_mem_arb.sv - cartridge read / ROM loader write arbiter for one shared word memory
module cart_mem_arb #(
    parameter int ADDR_W  = 21,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 63
) (
    input  logic              MCLK,
    input  logic              SRES,
    input  logic [ADDR_W-1:0] cart_address,
    input  logic              cart_cs,
    input  logic              cart_oe,
    output logic [DATA_W-1:0] cart_data,
    output logic              cart_valid,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              timeout_err
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RD_CMD, RD_WAIT, WR_CMD} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] tag_addr, tag_addr_nxt;
    logic              tag_valid, tag_valid_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] cart_data_nxt;
    logic              cart_valid_nxt;
    logic              ld_ack_nxt;
    logic              mem_req_nxt;
    logic              mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic              timeout_err_nxt;
    logic              sel;
    logic              hit;

    always_ff @(posedge MCLK or negedge SRES) begin
        if (!SRES) begin
            state       <= IDLE;
            tag_addr    <= '0;
            tag_valid   <= 1'b0;
            cnt         <= '0;
            cart_data   <= '1;
            cart_valid  <= 1'b0;
            ld_ack      <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            tag_addr    <= tag_addr_nxt;
            tag_valid   <= tag_valid_nxt;
            cnt         <= cnt_nxt;
            cart_data   <= cart_data_nxt;
            cart_valid  <= cart_valid_nxt;
            ld_ack      <= ld_ack_nxt;
            mem_req     <= mem_req_nxt;
            mem_we      <= mem_we_nxt;
            mem_addr    <= mem_addr_nxt;
            mem_wdata   <= mem_wdata_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        tag_addr_nxt    = tag_addr;
        tag_valid_nxt   = tag_valid;
        cnt_nxt         = cnt;
        cart_data_nxt   = cart_data;
        ld_ack_nxt      = 1'b0;
        mem_req_nxt     = mem_req;
        mem_we_nxt      = mem_we;
        mem_addr_nxt    = mem_addr;
        mem_wdata_nxt   = mem_wdata;
        timeout_err_nxt = timeout_err;

        sel = cart_cs & cart_oe;
        hit = sel & tag_valid & (cart_address == tag_addr);

        case (state)
            IDLE: begin
                if (sel && !hit) begin
                    state_nxt     = RD_CMD;
                    tag_addr_nxt  = cart_address;
                    tag_valid_nxt = 1'b0;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b0;
                    mem_addr_nxt  = cart_address;
                end else if (ld_req && !ld_ack) begin
                    // ld_req is still high in the ack cycle; that word is already written
                    state_nxt     = WR_CMD;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b1;
                    mem_addr_nxt  = ld_addr;
                    mem_wdata_nxt = ld_data;
                    if (tag_valid && (ld_addr == tag_addr)) begin
                        tag_valid_nxt = 1'b0;
                    end
                end
            end
            RD_CMD: begin
                if (mem_ready) begin
                    state_nxt   = RD_WAIT;
                    mem_req_nxt = 1'b0;
                    cnt_nxt     = '0;
                end
            end
            RD_WAIT: begin
                if (mem_rvalid) begin
                    cart_data_nxt = mem_rdata;
                    tag_valid_nxt = 1'b1;
                    state_nxt     = IDLE;
                end else if (cnt == TO_LAST) begin
                    cart_data_nxt   = '1;
                    timeout_err_nxt = 1'b1;
                    state_nxt       = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            WR_CMD: begin
                if (mem_ready) begin
                    mem_req_nxt = 1'b0;
                    mem_we_nxt  = 1'b0;
                    ld_ack_nxt  = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // evaluated against the post-edge tag so a fill or invalidate takes effect at once
        cart_valid_nxt = sel & tag_valid_nxt & (cart_address == tag_addr_nxt);
    end

endmodule

// File: tb/tb_cart_mem_arb.sv
// tb/tb_cart_mem_arb.sv - directed and randomized self-checking bench for cart_mem_arb
module tb_cart_mem_arb;

    localparam int AW = 21;
    localparam int DW = 16;
    localparam int TO = 63;

    logic          MCLK = 1'b0;
    logic          SRES;
    logic [AW-1:0] cart_address;
    logic          cart_cs, cart_oe;
    logic [DW-1:0] cart_data;
    logic          cart_valid;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_ack;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid;
    logic          timeout_err;

    cart_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .MCLK(MCLK), .SRES(SRES),
        .cart_address(cart_address), .cart_cs(cart_cs), .cart_oe(cart_oe),
        .cart_data(cart_data), .cart_valid(cart_valid),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .timeout_err(timeout_err)
    );

    always #5 MCLK = ~MCLK;

    int checks = 0;
    int errors = 0;

    // reference model: what the board and memory must observe
    typedef enum int {J_NONE, J_READ, J_WRITE} job_t;
    job_t          job;
    bit            rd_accepted;
    int            age;
    logic [AW-1:0] c_tag;
    bit            c_valid;
    logic [DW-1:0] e_data;
    bit            e_valid, e_ack, e_req, e_we, e_terr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;

    // memory environment
    logic [DW-1:0] gmem [int];
    int            rdy_pct = 100;
    int            lat_lo = 1, lat_hi = 1;
    bit            no_resp = 0;
    bit            auto_drop = 1;
    int            rv_cnt = 0;
    logic [DW-1:0] rv_data;
    int            req_cnt = 0, ack_cnt = 0;
    bit            prev_req = 0;
    logic          cmd_we_q[$];
    logic [AW-1:0] cmd_addr_q[$];
    logic [DW-1:0] cmd_data_q[$];
    logic [AW-1:0] pool [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] gread(input logic [AW-1:0] a);
        if (gmem.exists(int'(a))) return gmem[int'(a)];
        return a[15:0] ^ 16'h3C5A;
    endfunction

    task automatic model_reset();
        job = J_NONE; rd_accepted = 0; age = 0;
        c_tag = '0; c_valid = 0;
        e_data = '1; e_valid = 0; e_ack = 0; e_req = 0; e_we = 0;
        e_addr = '0; e_wdata = '0; e_terr = 0;
    endtask

    task automatic model_step();
        bit sel, hit, ack_now;
        if (!SRES) begin
            model_reset();
            return;
        end
        sel = cart_cs && cart_oe;
        hit = sel && c_valid && (cart_address == c_tag);
        ack_now = 0;
        case (job)
            J_NONE: begin
                if (sel && !hit) begin
                    job = J_READ; rd_accepted = 0;
                    c_tag = cart_address; c_valid = 0;
                    e_req = 1; e_we = 0; e_addr = cart_address;
                end else if (ld_req && !e_ack) begin
                    job = J_WRITE;
                    e_req = 1; e_we = 1; e_addr = ld_addr; e_wdata = ld_data;
                    if (c_valid && ld_addr == c_tag) c_valid = 0;
                end
            end
            J_READ: begin
                if (!rd_accepted) begin
                    if (mem_ready) begin rd_accepted = 1; age = 0; e_req = 0; end
                end else if (mem_rvalid) begin
                    e_data = mem_rdata; c_valid = 1; job = J_NONE;
                end else begin
                    age++;
                    if (age == TO) begin e_data = '1; e_terr = 1; job = J_NONE; end
                end
            end
            J_WRITE: begin
                if (mem_ready) begin e_req = 0; ack_now = 1; job = J_NONE; end
            end
            default: job = J_NONE;
        endcase
        e_ack = ack_now;
        e_valid = sel && c_valid && (cart_address == c_tag);
    endtask

    task automatic check_outputs();
        chk("cart_data", cart_data, e_data);
        chk("cart_valid", cart_valid, e_valid);
        chk("ld_ack", ld_ack, e_ack);
        chk("mem_req", mem_req, e_req);
        chk("timeout_err", timeout_err, e_terr);
        if (e_req) begin
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
        end
        if (e_valid) chk("coherent", cart_data, gread(cart_address));
    endtask

    task automatic mem_drive();
        if (mem_req && !prev_req) req_cnt++;
        prev_req = mem_req;
        if (ld_ack) begin
            ack_cnt++;
            if (auto_drop) ld_req = 0;
        end
        mem_rvalid = 0;
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) mem_rvalid = 1;
        end
        mem_rdata = mem_rvalid ? rv_data : DW'($urandom);
        mem_ready = ($urandom_range(0, 99) < rdy_pct);
        if (mem_req && mem_ready) begin
            cmd_we_q.push_back(mem_we);
            cmd_addr_q.push_back(mem_addr);
            cmd_data_q.push_back(mem_wdata);
            if (mem_we) gmem[int'(mem_addr)] = mem_wdata;
            else if (!no_resp) begin
                rv_cnt  = $urandom_range(lat_lo, lat_hi);
                rv_data = gread(mem_addr);
            end
        end
    endtask

    task automatic tick();
        @(posedge MCLK);
        model_step();
        @(negedge MCLK);
        check_outputs();
        mem_drive();
    endtask

    task automatic clear_log();
        cmd_we_q.delete(); cmd_addr_q.delete(); cmd_data_q.delete();
    endtask

    initial begin
        int r0, a0;
        SRES = 0; cart_address = '0; cart_cs = 0; cart_oe = 0;
        ld_req = 0; ld_addr = '0; ld_data = '0;
        mem_ready = 0; mem_rdata = '0; mem_rvalid = 0;
        model_reset();
        for (int i = 0; i < 8; i++) pool[i] = AW'($urandom);

        repeat (2) tick();
        chk("rst_cart_data", cart_data, 16'hFFFF);
        chk("rst_cart_valid", cart_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_ld_ack", ld_ack, 0);
        chk("rst_timeout_err", timeout_err, 0);
        SRES = 1;
        tick();

        // reset in the middle of a read
        rdy_pct = 100; lat_lo = 5; lat_hi = 5;
        cart_address = 21'h00100; cart_cs = 1; cart_oe = 1;
        tick();
        chk("midrd_req", mem_req, 1);
        chk("midrd_addr", mem_addr, 21'h00100);
        tick(); tick();
        #2 SRES = 0;
        #1;
        chk("midrd_rst_data", cart_data, 16'hFFFF);
        chk("midrd_rst_valid", cart_valid, 0);
        chk("midrd_rst_req", mem_req, 0);
        cart_cs = 0; rv_cnt = 0; mem_rvalid = 0; model_reset();
        tick(); tick();
        SRES = 1;
        r0 = req_cnt;
        repeat (4) tick();
        chk("midrd_quiet", req_cnt - r0, 0);

        // miss then hit
        gmem[32'h200] = 16'hA55A; lat_lo = 3; lat_hi = 3;
        cart_address = 21'h00200; cart_cs = 1;
        repeat (4) tick();
        chk("miss_early", cart_valid, 0);
        tick();
        chk("miss_valid", cart_valid, 1);
        chk("miss_data", cart_data, 16'hA55A);
        cart_cs = 0;
        tick();
        chk("miss_drop", cart_valid, 0);
        r0 = req_cnt;
        cart_cs = 1;
        tick();
        chk("hit_valid", cart_valid, 1);
        chk("hit_data", cart_data, 16'hA55A);
        repeat (3) tick();
        chk("hit_no_req", req_cnt - r0, 0);

        // cart and loader in the same cycle
        cart_cs = 0; tick();
        clear_log(); a0 = ack_cnt; lat_lo = 2; lat_hi = 2;
        cart_address = 21'h00020; cart_cs = 1;
        ld_req = 1; ld_addr = 21'h00010; ld_data = 16'h1234;
        repeat (15) tick();
        chk("sim_ncmd", cmd_we_q.size(), 2);
        if (cmd_we_q.size() >= 2) begin
            chk("sim_first_we", cmd_we_q[0], 0);
            chk("sim_first_addr", cmd_addr_q[0], 21'h00020);
            chk("sim_second_we", cmd_we_q[1], 1);
            chk("sim_second_addr", cmd_addr_q[1], 21'h00010);
            chk("sim_second_data", cmd_data_q[1], 16'h1234);
        end
        chk("sim_acks", ack_cnt - a0, 1);

        // loader write invalidates the cached word
        cart_cs = 0; ld_req = 0; tick();
        gmem[32'h300] = 16'h1111;
        cart_address = 21'h00300; cart_cs = 1;
        repeat (8) tick();
        chk("inv_pre_valid", cart_valid, 1);
        chk("inv_pre_data", cart_data, 16'h1111);
        clear_log();
        ld_addr = 21'h00300; ld_data = 16'h2222; ld_req = 1;
        tick();
        chk("inv_drop", cart_valid, 0);
        repeat (14) tick();
        chk("inv_valid", cart_valid, 1);
        chk("inv_data", cart_data, 16'h2222);
        chk("inv_ncmd", cmd_we_q.size(), 2);
        if (cmd_we_q.size() >= 2) begin
            chk("inv_first_we", cmd_we_q[0], 1);
            chk("inv_second_addr", cmd_addr_q[1], 21'h00300);
            chk("inv_second_we", cmd_we_q[1], 0);
        end

        // backpressure in RD_CMD, then a read that never returns
        cart_cs = 0; tick();
        no_resp = 1; rdy_pct = 0;
        cart_address = 21'h00400; cart_cs = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_req", mem_req, 1);
            chk("bp_addr", mem_addr, 21'h00400);
        end
        rdy_pct = 100;
        tick();
        chk("bp_req_last", mem_req, 1);
        tick();
        chk("bp_accepted", mem_req, 0);
        repeat (62) tick();
        chk("to_early", timeout_err, 0);
        cart_cs = 0;
        tick();
        chk("to_err", timeout_err, 1);
        chk("to_data", cart_data, 16'hFFFF);
        chk("to_valid", cart_valid, 0);
        no_resp = 0;
        tick();
        mem_rvalid = 1; mem_rdata = 16'h1357;
        tick();
        chk("late_data", cart_data, 16'hFFFF);
        chk("late_valid", cart_valid, 0);
        lat_lo = 1; lat_hi = 4;
        cart_cs = 1;
        repeat (10) tick();
        chk("recover_valid", cart_valid, 1);
        chk("recover_data", cart_data, 16'h385A);
        chk("recover_err_sticky", timeout_err, 1);
        cart_cs = 0;
        SRES = 0;
        tick(); tick();
        chk("rst_clears_err", timeout_err, 0);
        SRES = 1;
        tick();

        // randomized traffic
        rdy_pct = 70; lat_lo = 1; lat_hi = 6; auto_drop = 0;
        cart_oe = 1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(0, 99) < 8) cart_cs = ~cart_cs;
            if ($urandom_range(0, 99) < 4) cart_oe = ~cart_oe;
            if ($urandom_range(0, 99) < 10) cart_address = pool[$urandom_range(0, 7)];
            if (ld_req) begin
                if (ld_ack) begin
                    if ($urandom_range(0, 1) == 0) ld_req = 0;
                    else begin
                        ld_addr = pool[$urandom_range(0, 7)];
                        ld_data = DW'($urandom);
                    end
                end
            end else if ($urandom_range(0, 99) < 6) begin
                ld_req = 1;
                ld_addr = pool[$urandom_range(0, 7)];
                ld_data = DW'($urandom);
            end
        end
        ld_req = 0; cart_cs = 0;
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
